// File: rtl/mult_share_arb.sv
// mult_share_arb -- round-robin scheduler sharing one pipelined multiplier
// among NUM_REQ requesters.
//
// One operand pair is granted per cycle, registered into the external
// multiplier, and its requester ID travels down a tag pipeline whose depth
// equals the multiplier latency. The product is then routed back to its
// requester.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   en              grant enable; in-flight work still completes when low
//   req_valid       per-requester operand valid
//   req_ready       one-hot grant (combinational)
//   req_a, req_b    flattened operands, requester i at [(i+1)*W-1 -: W]
//   mult_in_valid   operands valid to the multiplier
//   mult_a, mult_b  multiplier operands
//   mult_p          multiplier product, MULT_LAT cycles after mult_in_valid
//   rsp_valid       one-hot result valid
//   rsp_id          requester index of the current result
//   rsp_data        product
//   busy            any transfer in flight
//
// Optional build macro MULT_SHARE_STATS_EN adds:
//   grant_cnt       NUM_REQ x 16-bit saturating transfer counters
//   idle_cnt        16-bit saturating count of enabled cycles without transfer

`ifndef WIDTH_DATA
`define WIDTH_DATA 16
`endif

module mult_share_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MULT_LAT   = 3,
  parameter int unsigned WIDTH_DATA = `WIDTH_DATA,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WIDTH_DATA-1:0] req_a,
  input  logic [NUM_REQ*WIDTH_DATA-1:0] req_b,
  output logic                          mult_in_valid,
  output logic [WIDTH_DATA-1:0]         mult_a,
  output logic [WIDTH_DATA-1:0]         mult_b,
  input  logic [2*WIDTH_DATA-1:0]       mult_p,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [2*WIDTH_DATA-1:0]       rsp_data,
  output logic                          busy
`ifdef MULT_SHARE_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt,
  output logic [15:0]                   idle_cnt
`endif
);

  logic [ID_W-1:0]                ptr;
  logic [ID_W-1:0]                grant;
  logic                           found;
  logic                           xfer;
  logic [WIDTH_DATA-1:0]          sel_a;
  logic [WIDTH_DATA-1:0]          sel_b;
  logic [ID_W-1:0]                issue_id;
  logic [MULT_LAT-1:0]            tag_v;
  logic [MULT_LAT-1:0][ID_W-1:0]  tag_id;
  logic [NUM_REQ-1:0]             rsp_onehot;

  // Rotating priority: the first pass only considers indices at or above
  // ptr; if none is valid the second pass takes the lowest valid index,
  // which is the wrap-around continuation of the search.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) >= ptr)) begin
        found = 1'b1;
        grant = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        grant = ID_W'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!rst && en && found && (grant == ID_W'(i)))
        req_ready[i] = 1'b1;
      if (grant == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH_DATA +: WIDTH_DATA];
        sel_b = req_b[i*WIDTH_DATA +: WIDTH_DATA];
      end
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    rsp_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      rsp_onehot[i] = tag_v[MULT_LAT-1] && (tag_id[MULT_LAT-1] == ID_W'(i));
  end

  // Tag stage 0 is loaded from the issue register, so the tail lines up
  // with the cycle mult_p carries the matching product.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      mult_in_valid <= 1'b0;
      mult_a        <= '0;
      mult_b        <= '0;
      issue_id      <= '0;
      tag_v         <= '0;
      tag_id        <= '0;
      rsp_valid     <= '0;
      rsp_id        <= '0;
      rsp_data      <= '0;
    end else begin
      mult_in_valid <= xfer;
      if (xfer) begin
        ptr      <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
        mult_a   <= sel_a;
        mult_b   <= sel_b;
        issue_id <= grant;
      end
      tag_v[0]  <= mult_in_valid;
      tag_id[0] <= issue_id;
      for (int unsigned k = 1; k < MULT_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      rsp_valid <= rsp_onehot;
      if (tag_v[MULT_LAT-1]) begin
        rsp_id   <= tag_id[MULT_LAT-1];
        rsp_data <= mult_p;
      end
    end
  end

  assign busy = mult_in_valid | (|tag_v) | (|rsp_valid);

`ifdef MULT_SHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF))
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (en && !xfer && (idle_cnt != 16'hFFFF))
        idle_cnt <= idle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb (NUM_REQ=4, MULT_LAT=3, WIDTH_DATA=16).
// A behavioural 3-stage multiplier feeds mult_p; expected values are
// hand-computed constants.
module tb_mult_share_arb;
  localparam int unsigned NR = 4;
  localparam int unsigned ML = 3;
  localparam int unsigned W  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic            mult_in_valid;
  logic [W-1:0]    mult_a;
  logic [W-1:0]    mult_b;
  logic [2*W-1:0]  mult_p;
  logic [NR-1:0]   rsp_valid;
  logic [1:0]      rsp_id;
  logic [2*W-1:0]  rsp_data;
  logic            busy;
`ifdef MULT_SHARE_STATS_EN
  logic [NR*16-1:0] grant_cnt;
  logic [15:0]      idle_cnt;
`endif

  int tests = 0;
  int fails = 0;

  mult_share_arb #(
    .NUM_REQ   (NR),
    .MULT_LAT  (ML),
    .WIDTH_DATA(W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .mult_in_valid(mult_in_valid),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_p       (mult_p),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .busy         (busy)
`ifdef MULT_SHARE_STATS_EN
    ,
    .grant_cnt    (grant_cnt),
    .idle_cnt     (idle_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural multiplier with ML cycles of latency.
  logic [2*W-1:0] mpipe [ML];
  always @(posedge clk) begin
    mpipe[0] <= 32'(mult_a) * 32'(mult_b);
    for (int k = 1; k < ML; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mult_p = mpipe[ML-1];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < ML; k++) mpipe[k] = '0;
    rst = 1'b1; en = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0;
    #1;
    chk("ready_in_rst", 64'(req_ready), 64'h0);
    tick(2);
    chk("rst_in_valid", 64'(mult_in_valid), 64'h0);
    chk("rst_mult_a", 64'(mult_a), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data", 64'(rsp_data), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0; req_valid = '0;
    tick(1);

    // 1: single requester 1, 3*7
    set_op(1, 16'h0003, 16'h0007);
    req_valid = 4'b0010;
    #1;
    chk("t1_ready", 64'(req_ready), 64'h2);
    tick(1);
    req_valid = '0;
    chk("t1_in_valid", 64'(mult_in_valid), 64'h1);
    chk("t1_mult_a", 64'(mult_a), 64'h3);
    chk("t1_mult_b", 64'(mult_b), 64'h7);
    chk("t1_busy", 64'(busy), 64'h1);
    tick(3);
    chk("t1_not_early", 64'(rsp_valid), 64'h0);
    tick(1);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("t1_rsp_id", 64'(rsp_id), 64'h1);
    chk("t1_rsp_data", 64'(rsp_data), 64'h15);
    tick(1);
    chk("t1_rsp_clear", 64'(rsp_valid), 64'h0);
    chk("t1_rsp_hold", 64'(rsp_data), 64'h15);

    // 2: bring ptr to 0 via requester 3, then full-load round robin
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'h0002);
    req_valid = 4'b1000;
    #1;
    chk("t2_pre_ready", 64'(req_ready), 64'h8);
    tick(1);
    for (int j = 0; j < 14; j++) begin
      req_valid = (j < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (j < 8) chk("t2_grant", 64'(req_ready), 64'(1 << (j % 4)));
      if (j == 4) begin
        chk("t2_pre_rsp", 64'(rsp_valid), 64'h8);
        chk("t2_pre_data", 64'(rsp_data), 64'h8);
      end
      if (j >= 5 && j <= 12) begin
        chk("t2_rsp_valid", 64'(rsp_valid), 64'(1 << ((j - 5) % 4)));
        chk("t2_rsp_id", 64'(rsp_id), 64'((j - 5) % 4));
        chk("t2_rsp_data", 64'(rsp_data), 64'(2 * ((j - 5) % 4 + 1)));
      end
      tick(1);
    end
    chk("t2_idle", 64'(rsp_valid), 64'h0);

    // 3: wrap and pointer skip
    req_valid = 4'b1000;
    #1;
    chk("t3_grant3", 64'(req_ready), 64'h8);
    tick(1);
    req_valid = 4'b0101;
    #1;
    chk("t3_grant0a", 64'(req_ready), 64'h1);
    tick(1);
    #1;
    chk("t3_grant2", 64'(req_ready), 64'h4);
    tick(1);
    #1;
    chk("t3_grant0b", 64'(req_ready), 64'h1);
    tick(1);
    req_valid = '0;
    tick(6);

    // 4: en gating with three in flight; ptr=1 -> grants 1,2,0
    set_op(0, 16'h0010, 16'h0010);
    set_op(1, 16'hFFFF, 16'hFFFF);
    set_op(2, 16'h1234, 16'h0000);
    req_valid = 4'b0111;
    #1;
    chk("t4_g1", 64'(req_ready), 64'h2);
    tick(1);
    #1;
    chk("t4_g2", 64'(req_ready), 64'h4);
    tick(1);
    #1;
    chk("t4_g0", 64'(req_ready), 64'h1);
    tick(1);
    for (int e = 3; e <= 8; e++) begin
      en = 1'b0;
      #1;
      chk("t4_ready_off", 64'(req_ready), 64'h0);
      if (e == 5) begin
        chk("t4_rsp1_v", 64'(rsp_valid), 64'h2);
        chk("t4_rsp1_id", 64'(rsp_id), 64'h1);
        chk("t4_rsp1_d", 64'(rsp_data), 64'hFFFE0001);
      end
      if (e == 6) begin
        chk("t4_rsp2_v", 64'(rsp_valid), 64'h4);
        chk("t4_rsp2_id", 64'(rsp_id), 64'h2);
        chk("t4_rsp2_d", 64'(rsp_data), 64'h0);
      end
      if (e == 7) begin
        chk("t4_rsp0_v", 64'(rsp_valid), 64'h1);
        chk("t4_rsp0_id", 64'(rsp_id), 64'h0);
        chk("t4_rsp0_d", 64'(rsp_data), 64'h100);
        chk("t4_busy_last", 64'(busy), 64'h1);
      end
      if (e == 8) begin
        chk("t4_rsp_done", 64'(rsp_valid), 64'h0);
        chk("t4_busy_low", 64'(busy), 64'h0);
      end
      tick(1);
    end
    en = 1'b1;
    #1;
    chk("t4_ptr_frozen", 64'(req_ready), 64'h2);
    req_valid = '0;
    tick(1);

    // 5: reset mid-flight; ptr=1 -> grants 1 then 0, rst on the third cycle
    set_op(0, 16'h0005, 16'h0005);
    set_op(1, 16'h0006, 16'h0006);
    req_valid = 4'b0011;
    #1;
    chk("t5_g1", 64'(req_ready), 64'h2);
    tick(1);
    #1;
    chk("t5_g0", 64'(req_ready), 64'h1);
    tick(1);
    rst = 1'b1;
    #1;
    chk("t5_ready_rst", 64'(req_ready), 64'h0);
    tick(1);
    rst = 1'b0;
    req_valid = '0;
    chk("t5_in_valid", 64'(mult_in_valid), 64'h0);
    chk("t5_mult_a", 64'(mult_a), 64'h0);
    chk("t5_mult_b", 64'(mult_b), 64'h0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("t5_rsp_id", 64'(rsp_id), 64'h0);
    chk("t5_rsp_data", 64'(rsp_data), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);
    set_op(2, 16'h8000, 16'h0002);
    req_valid = 4'b0100;
    #1;
    chk("t5_new_grant", 64'(req_ready), 64'h4);
    tick(1);
    req_valid = '0;
    for (int c = 4; c <= 8; c++) begin
      if (c < 8) begin
        chk("t5_no_stale", 64'(rsp_valid), 64'h0);
      end else begin
        chk("t5_new_valid", 64'(rsp_valid), 64'h4);
        chk("t5_new_id", 64'(rsp_id), 64'h2);
        chk("t5_new_data", 64'(rsp_data), 64'h00010000);
      end
      tick(1);
    end

`ifdef MULT_SHARE_STATS_EN
    // 6: counter saturation
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    en = 1'b1;
    req_valid = '0;
    tick(3);
    req_valid = 4'b0001;
    tick(70000);
    req_valid = '0;
    en = 1'b0;
    tick(1);
    chk("t6_grant0_sat", 64'(grant_cnt[15:0]), 64'hFFFF);
    chk("t6_grant_others", 64'(grant_cnt[63:16]), 64'h0);
    chk("t6_idle_cnt", 64'(idle_cnt), 64'h3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
